// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, reset PC, opcodes, offset field.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

  // PC held during and immediately after reset (-4)
  localparam logic [31:0] CPU_RESET_PC = 32'hFFFF_FFFC;

  localparam logic [7:0] OP_J   = 8'h06;
  localparam logic [7:0] OP_BEQ = 8'h07;

  // Bit range of the signed word offset inside an instruction
  localparam int OFFSET_HI = 23;
  localparam int OFFSET_LO = 16;

  function automatic logic [7:0] offset_field(input logic [31:0] instr);
    return instr[OFFSET_HI:OFFSET_LO];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// next_pc_calc: combinational next-PC selection (sequential, jump, taken branch).
// Shared with the pipelined fetch variant.
module next_pc_calc (
  input  logic [31:0] pc,
  input  logic [7:0]  offset,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic signed [31:0] offset_ext;
  logic               take;

  // Sign-extend the word offset to a byte offset; jump wins over branch
  // because either one alone selects the same target.
  always_comb begin
    offset_ext = {{22{offset[7]}}, offset, 2'b00};
    take       = jump | (branch & zero);
    next_pc    = pc + 32'd4 + (take ? $unsigned(offset_ext) : 32'd0);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches from instruction memory, holds the
// instruction for control_unit, and advances the PC after execution.
// Optional build macro: INSTR_FETCH_RETIRE_COUNT_EN adds a RETIRED counter output.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          IMEM_ADDR_W = 8,
  parameter logic [31:0] RESET_PC    = CPU_RESET_PC
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [31:0]            IMEM_READDATA,
  input  logic                   IMEM_BUSYWAIT,
  input  logic                   DMEM_BUSYWAIT,
  input  logic                   JUMP,
  input  logic                   BRANCH,
  input  logic                   ZERO,
  output logic                   IMEM_READ,
  output logic [IMEM_ADDR_W-1:0] IMEM_ADDRESS,
  output logic [31:0]            PC,
  output logic [31:0]            INSTRUCTION,
  output logic                   INSTR_VALID
`ifdef INSTR_FETCH_RETIRE_COUNT_EN
  ,
  output logic [31:0]            RETIRED
`endif
);

  fetch_state_t state, state_nxt;
  logic         fetch_done;
  logic         exec_exit;
  logic [31:0]  next_pc;

  assign fetch_done   = (state == FETCH) && !IMEM_BUSYWAIT;
  assign exec_exit    = (state == EXEC) && !DMEM_BUSYWAIT;
  assign IMEM_ADDRESS = PC[IMEM_ADDR_W+1:2];

  next_pc_calc u_next_pc (
    .pc      (PC),
    .offset  (offset_field(INSTRUCTION)),
    .jump    (JUMP),
    .branch  (BRANCH),
    .zero    (ZERO),
    .next_pc (next_pc)
  );

  // FSM state register; reset abandons any in-flight fetch
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= BOOT;
    else        state <= state_nxt;
  end

  // FSM next state and memory read request
  always_comb begin
    state_nxt = state;
    IMEM_READ = 1'b0;
    case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: begin
        IMEM_READ = 1'b1;
        if (!IMEM_BUSYWAIT) state_nxt = EXEC;
      end
      EXEC:  if (!DMEM_BUSYWAIT) state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  // Program counter: leaves the reset value on the first edge, then advances on EXEC exit
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)             PC <= RESET_PC;
    else if (state == BOOT) PC <= 32'h0;
    else if (exec_exit)     PC <= next_pc;
  end

  // Instruction register captures memory data only when a fetch completes
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)          INSTRUCTION <= 32'h0;
    else if (fetch_done) INSTRUCTION <= IMEM_READDATA;
  end

  // Valid flag; never asserted for an instruction sitting at the reset PC,
  // where control_unit must not commit anything
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)          INSTR_VALID <= 1'b0;
    else if (fetch_done) INSTR_VALID <= (PC != RESET_PC);
    else if (exec_exit)  INSTR_VALID <= 1'b0;
  end

`ifdef INSTR_FETCH_RETIRE_COUNT_EN
  // Retired-instruction counter, one per EXEC exit, wraps silently
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)         RETIRED <= 32'h0;
    else if (exec_exit) RETIRED <= RETIRED + 32'd1;
  end
`else
  // No retire counter in this build
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit (optional RETIRED checks under
// INSTR_FETCH_RETIRE_COUNT_EN).
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RESET;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;
  logic        DMEM_BUSYWAIT;
  logic        JUMP;
  logic        BRANCH;
  logic        ZERO;
  logic        IMEM_READ;
  logic [7:0]  IMEM_ADDRESS;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
`ifdef INSTR_FETCH_RETIRE_COUNT_EN
  logic [31:0] RETIRED;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] imem [256];

  instr_fetch_unit dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .IMEM_READDATA (IMEM_READDATA),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .DMEM_BUSYWAIT (DMEM_BUSYWAIT),
    .JUMP          (JUMP),
    .BRANCH        (BRANCH),
    .ZERO          (ZERO),
    .IMEM_READ     (IMEM_READ),
    .IMEM_ADDRESS  (IMEM_ADDRESS),
    .PC            (PC),
    .INSTRUCTION   (INSTRUCTION),
    .INSTR_VALID   (INSTR_VALID)
`ifdef INSTR_FETCH_RETIRE_COUNT_EN
    ,
    .RETIRED       (RETIRED)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign IMEM_READDATA = imem[IMEM_ADDRESS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full instruction from FETCH: fetch edge, then EXEC exit edge with given controls
  task automatic step_instr(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr,
                            input logic j, input logic b, input logic z,
                            input logic [31:0] exp_next, input logic exp_valid);
    logic [31:0] a;
    a = {24'h0, exp_pc[9:2]};
    chk({tag, ".fetch_pc"}, PC, exp_pc);
    chk({tag, ".fetch_addr"}, {24'h0, IMEM_ADDRESS}, a);
    chk({tag, ".fetch_read"}, {31'h0, IMEM_READ}, 32'd1);
    chk({tag, ".fetch_valid"}, {31'h0, INSTR_VALID}, 32'd0);
    tick();
    chk({tag, ".exec_instr"}, INSTRUCTION, exp_instr);
    chk({tag, ".exec_valid"}, {31'h0, INSTR_VALID}, {31'h0, exp_valid});
    chk({tag, ".exec_read"}, {31'h0, IMEM_READ}, 32'd0);
    chk({tag, ".exec_pc"}, PC, exp_pc);
    JUMP = j; BRANCH = b; ZERO = z;
    tick();
    JUMP = 1'b0; BRANCH = 1'b0; ZERO = 1'b0;
    chk({tag, ".next_pc"}, PC, exp_next);
    chk({tag, ".next_valid"}, {31'h0, INSTR_VALID}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    imem[0]   = 32'h0000_0001;
    imem[1]   = 32'h0703_0000;   // beq +3
    imem[2]   = 32'h06FE_0000;   // j -2
    imem[3]   = 32'h06FD_0000;   // j -3
    imem[5]   = 32'h0701_0000;   // offset +1
    imem[7]   = 32'h06F6_0000;   // j -10
    imem[254] = 32'h0000_ABCD;
    imem[255] = 32'h1234_5678;

    RESET = 1'b0; IMEM_BUSYWAIT = 1'b0; DMEM_BUSYWAIT = 1'b0;
    JUMP = 1'b0; BRANCH = 1'b0; ZERO = 1'b0;

    // Reset held for 3 cycles
    repeat (3) tick();
    chk("rst.pc", PC, 32'hFFFF_FFFC);
    chk("rst.valid", {31'h0, INSTR_VALID}, 32'd0);
    chk("rst.read", {31'h0, IMEM_READ}, 32'd0);
    chk("rst.addr", {24'h0, IMEM_ADDRESS}, 32'h0000_00FF);
    chk("rst.instr", INSTRUCTION, 32'h0);

    // First edge after release: BOOT -> FETCH at PC 0
    RESET = 1'b1;
    tick();
    chk("boot.pc", PC, 32'h0);
    chk("boot.read", {31'h0, IMEM_READ}, 32'd1);
    chk("boot.addr", {24'h0, IMEM_ADDRESS}, 32'h0);

    // Sequential 0,4,8,12 then jumps and branches
    step_instr("seq0", 32'd0,  32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'd4,  1'b1);
    step_instr("seq4", 32'd4,  32'h0703_0000, 1'b0, 1'b0, 1'b0, 32'd8,  1'b1);
    step_instr("seq8", 32'd8,  32'h06FE_0000, 1'b0, 1'b0, 1'b0, 32'd12, 1'b1);
    step_instr("jm3",  32'd12, 32'h06FD_0000, 1'b1, 1'b0, 1'b0, 32'd4,  1'b1);
    step_instr("bnz",  32'd4,  32'h0703_0000, 1'b0, 1'b1, 1'b0, 32'd8,  1'b1);
    step_instr("jm2",  32'd8,  32'h06FE_0000, 1'b1, 1'b0, 1'b0, 32'd4,  1'b1);
    step_instr("btk",  32'd4,  32'h0703_0000, 1'b0, 1'b1, 1'b1, 32'd20, 1'b1);

    // Instruction-memory stall at PC 20
    IMEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("istall.pc", PC, 32'd20);
      chk("istall.addr", {24'h0, IMEM_ADDRESS}, 32'd5);
      chk("istall.read", {31'h0, IMEM_READ}, 32'd1);
      chk("istall.valid", {31'h0, INSTR_VALID}, 32'd0);
    end
    IMEM_BUSYWAIT = 1'b0;
    tick();
    chk("istall.instr", INSTRUCTION, 32'h0701_0000);
    chk("istall.valid_up", {31'h0, INSTR_VALID}, 32'd1);

    // Data-memory stall in EXEC; jump+branch(zero=0) applied: jump must win
    DMEM_BUSYWAIT = 1'b1;
    JUMP = 1'b1; BRANCH = 1'b1; ZERO = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dstall.pc", PC, 32'd20);
      chk("dstall.instr", INSTRUCTION, 32'h0701_0000);
      chk("dstall.valid", {31'h0, INSTR_VALID}, 32'd1);
    end
    DMEM_BUSYWAIT = 1'b0;
    tick();
    JUMP = 1'b0; BRANCH = 1'b0; ZERO = 1'b0;
    chk("dstall.next_pc", PC, 32'd28);
    chk("dstall.next_valid", {31'h0, INSTR_VALID}, 32'd0);

    // Backward jump below zero, then wrap up to the reset PC and past it
    step_instr("jneg",  32'd28,         32'h06F6_0000, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 1'b1);
    step_instr("wrap",  32'hFFFF_FFF8,  32'h0000_ABCD, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1);
    step_instr("rstpc", 32'hFFFF_FFFC,  32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0);
`ifdef INSTR_FETCH_RETIRE_COUNT_EN
    chk("retired.count", RETIRED, 32'd11);
`endif

    // Asynchronous reset mid-FETCH with instruction memory busy
    IMEM_BUSYWAIT = 1'b1;
    tick();
    chk("arst.pre_pc", PC, 32'h0);
    #2;
    RESET = 1'b0;
    #1;
    chk("arst.pc", PC, 32'hFFFF_FFFC);
    chk("arst.read", {31'h0, IMEM_READ}, 32'd0);
    chk("arst.valid", {31'h0, INSTR_VALID}, 32'd0);
    chk("arst.instr", INSTRUCTION, 32'h0);
`ifdef INSTR_FETCH_RETIRE_COUNT_EN
    chk("arst.retired", RETIRED, 32'd0);
`endif
    // Late memory data while in reset is ignored
    IMEM_BUSYWAIT = 1'b0;
    tick();
    chk("arst.hold_pc", PC, 32'hFFFF_FFFC);
    chk("arst.hold_instr", INSTRUCTION, 32'h0);
    RESET = 1'b1;
    tick();
    chk("arst.boot_pc", PC, 32'h0);
    step_instr("post", 32'd0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'd4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
